// File: rtl/lbll_key_pkg.sv
// Shared types and helpers for the locking-key loader: FSM states and the
// bit-serial CRC-8 step used to verify the incoming key stream.
package lbll_key_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_LOADED,
    ST_ERROR
  } state_t;

  // One MSB-first CRC step: init 0, no reflection, no final XOR.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic             din,
                                                 input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/lbll_crc8_serial.sv
// Bit-serial CRC-8 register with synchronous clear; shared by the key loader
// and, later, the key transmitter.
module lbll_crc8_serial
  import lbll_key_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_reg;

  // Clear wins over enable so a restart never folds in a stale bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (clr) begin
      crc_reg <= '0;
    end else if (en) begin
      crc_reg <= crc8_step(crc_reg, din, POLY);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/lbll_key_loader.sv
// Receives the locking key serially (MSB first, then CRC-8), verifies it and
// presents it to the locked core, which is held in reset until then.
module lbll_key_loader
  import lbll_key_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_sin,
  input  logic             key_sin_valid,
  output logic             key_sin_ready,
  output logic [NBITS-1:0] lbll_key,
  output logic             key_valid,
  output logic             key_err,
  output logic             core_rst
);

  localparam int LAST  = NBITS + CRC_W - 1;
  localparam int CNT_W = $clog2(NBITS + CRC_W);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NBITS-1:0]   shadow_reg;
  logic [NBITS-1:0]   shadow_next;
  logic [CRC_W-1:0]   rx_crc_reg;
  logic [CRC_W-1:0]   crc_calc;
  logic               accept;
  logic               key_phase;
  logic               crc_en;

  assign accept    = key_sin_valid & key_sin_ready;
  assign key_phase = cnt_reg < CNT_W'(NBITS);
  assign crc_en    = accept & key_phase & ~key_start;

  always_comb begin
    shadow_next    = shadow_reg << 1;
    shadow_next[0] = key_sin;
  end

  lbll_crc8_serial #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (key_start),
    .en   (crc_en),
    .din  (key_sin),
    .crc  (crc_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shadow_reg    <= '0;
      rx_crc_reg    <= '0;
      lbll_key      <= '0;
      key_valid     <= 1'b0;
      key_err       <= 1'b0;
      key_sin_ready <= 1'b0;
      core_rst      <= 1'b1;
    end else if (key_start) begin
      // Restart from any state; a bit offered in this cycle is dropped.
      state_reg     <= ST_SHIFT;
      cnt_reg       <= '0;
      shadow_reg    <= '0;
      rx_crc_reg    <= '0;
      lbll_key      <= '0;
      key_valid     <= 1'b0;
      key_err       <= 1'b0;
      key_sin_ready <= 1'b1;
      core_rst      <= 1'b1;
    end else begin
      case (state_reg)
        ST_SHIFT: begin
          if (accept) begin
            if (key_phase) begin
              shadow_reg <= shadow_next;
            end else begin
              rx_crc_reg <= {rx_crc_reg[CRC_W-2:0], key_sin};
            end
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(LAST)) begin
              state_reg     <= ST_CHECK;
              key_sin_ready <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (crc_calc == rx_crc_reg) begin
            state_reg <= ST_LOADED;
            lbll_key  <= shadow_reg;
            key_valid <= 1'b1;
          end else begin
            state_reg <= ST_ERROR;
            key_err   <= 1'b1;
          end
        end
        // Release one edge after key_valid so the core sees a settled key.
        ST_LOADED: core_rst <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lbll_key_loader.md
Name: lbll_key_loader

Overview:
- On-chip reader for the locking key; the hardware counterpart of the key file a bench loads into a locked design.
- Accepts the key as a serial bit stream with a valid/ready handshake, MSB first (same order as the key file text), followed by an 8-bit CRC.
- Checks the CRC, then presents the parallel key to a locked core such as iir_MODE_NBITS through its lbll_MODE_key port.
- Holds that core in reset until a verified key is in place.

Parameters:
- NBITS, 32, key width in bits; must equal the locked core's key width; legal range 1..1024.
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_start  input  1  one-cycle pulse; begins or restarts a load.
- key_sin  input  1  serial key/CRC bit.
- key_sin_valid  input  1  key_sin carries a bit this cycle.
- key_sin_ready  output  1  loader accepts a bit this cycle.
- lbll_key  output  NBITS  verified key to the locked core.
- key_valid  output  1  lbll_key holds a CRC-verified key.
- key_err  output  1  last load failed the CRC check; sticky until next key_start.
- core_rst  output  1  active-high reset for the locked core.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - lbll_key=0, key_valid=0, key_err=0, key_sin_ready=0, core_rst=1.
  - Internal counter, shadow register and CRC all 0.
- States:
  - IDLE: wait for key_start.
  - SHIFT: key_sin_ready=1.
  - CHECK: one cycle; key_sin_ready=0.
  - LOADED: key_valid=1.
  - ERROR: key_err=1.
- key_start in any state, SHIFT included (restart), takes effect on the next edge:
  - Enter SHIFT; clear counter, shadow and CRC.
  - Clear lbll_key to 0, key_valid=0, key_err=0, core_rst=1.
  - The core never sees a partial or stale key.
  - key_start has priority over a bit accepted in the same cycle; that bit is discarded.
- Bit accepted on an edge where key_sin_valid & key_sin_ready. Counter counts accepted bits, 0..NBITS+7.
- Bits 0..NBITS-1 (key bits):
  - Shadow shifts left, key_sin enters the LSB, so the first bit lands in bit NBITS-1.
  - CRC update per key bit: fb = crc[7]^key_sin; crc = {crc[6:0],0} ^ (fb ? CRC_POLY : 0). Init 0, no final XOR.
- Bits NBITS..NBITS+7: shifted MSB first into an 8-bit received-CRC register.
- Edge accepting bit NBITS+7 -> CHECK. key_sin_ready falls in the same cycle, so no further bits are accepted.
- CHECK, next edge:
  - Computed == received: go to LOADED; lbll_key <= shadow; key_valid <= 1.
  - Mismatch: go to ERROR; key_err <= 1; lbll_key stays 0.
- core_rst deasserts one edge after key_valid rises. The core therefore sees a stable key for at least one cycle before leaving reset.
- Once LOADED is entered, core_rst stays 0 until key_start or rst_n.
- ERROR: core_rst stays 1.
- Idle gaps (key_sin_valid low) in SHIFT are unlimited; no timeout.
- Latency: last CRC bit accepted at edge T -> key_valid=1 after T+1 -> core_rst=0 after T+2.
- rst_n assertion mid-load aborts immediately; outputs return to reset values.

Decomposition:
- Package lbll_key_pkg holds:
  - state enum (IDLE, SHIFT, CHECK, LOADED, ERROR);
  - CRC_W=8 and the default CRC_POLY constant;
  - function crc8_step(crc, bit, poly).
- Sub-module lbll_crc8_serial: bit-serial CRC register with clear and enable, instantiated once, for reuse by a future key-transmitter block.
- FSM, counter, shadow and received-CRC registers stay in lbll_key_loader.

Test Plan:
- Reset: rst_n low for 2 cycles -> lbll_key=0, key_valid=0, key_err=0, core_rst=1, key_sin_ready=0; all stay so with no key_start.
- Good load (NBITS=32): key_start; stream 32'h00000001 then CRC 8'h07 with valid held high -> key_sin_ready low from the cycle after the last bit; key_valid=1 after edge T+1; lbll_key=32'h00000001; core_rst=0 after T+2.
- Bad CRC: same key with CRC 8'h06 -> key_err=1, key_valid=0, lbll_key=0, core_rst stays 1.
- Gapped stream: key 32'hA5A5_0F0F, key_sin_valid toggled pseudo-randomly with its correct CRC -> result identical to the ungapped load; bit count exact, no bits dropped or duplicated.
- Restart:
  - key_start after 17 bits, then a full good load -> only the second stream is used.
  - key_start while LOADED -> key_valid=0, lbll_key=0, core_rst=1 on the next edge.
- Async abort and end-to-end: rst_n low mid-SHIFT -> immediate reset values. Then load the key from the .key file into loader + iir_MODE_NBITS; after core_rst falls, drive 30 random inputs and compare against the unlocked iir, with 50 cycles between each new input -> all match.
